// File: rtl/sc_preamble_inserter_if.sv
// sc_preamble_inserter_if: 32-bit I/Q sample stream (I in [31:16], Q in [15:0]).
// master drives tdata/tlast/tvalid and samples tready; slave is the mirror.
interface sc_preamble_inserter_if;
    logic [31:0] tdata;
    logic        tlast;
    logic        tvalid;
    logic        tready;
    modport master(output tdata, tlast, tvalid, input tready);
    modport slave(input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/sc_preamble_inserter.sv
// sc_preamble_inserter: prefixes each payload frame with R repetitions of a P-entry preamble table and G zero samples.
// Ports: clk/resetn (sync, active-low), clear (frame abort), set_stb/set_addr/set_data (settings bus),
// i (payload stream in), o (registered stream out), busy (frame in progress).
module sc_preamble_inserter #(
    parameter int BASE         = 0,
    parameter int MAX_LEN_LOG2 = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       clear,
    input  logic                       set_stb,
    input  logic [7:0]                 set_addr,
    input  logic [31:0]                set_data,
    sc_preamble_inserter_if.slave      i,
    sc_preamble_inserter_if.master     o,
    output logic                       busy
);
    localparam int AW = MAX_LEN_LOG2;
    localparam logic [7:0] A_P = 8'(BASE);
    localparam logic [7:0] A_R = 8'(BASE + 1);
    localparam logic [7:0] A_G = 8'(BASE + 2);
    localparam logic [7:0] A_T = 8'(BASE + 3);
    localparam logic [7:0] A_W = 8'(BASE + 4);

    typedef enum logic [1:0] {IDLE, PREAMBLE, GAP, PAYLOAD} state_t;

    state_t        state, state_n;
    logic [AW-1:0] per, per_s, idx, idx_n, wptr;
    logic [7:0]    reps, reps_s, rep, rep_n;
    logic [15:0]   gap, gap_s, gcnt, gcnt_n;
    logic [31:0]   mem [2**AW];
    logic [31:0]   rd, emit_data;
    logic          load, emit, emit_last;

    assign load = o.tready | ~o.tvalid;
    assign busy = state != IDLE;

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        rep_n     = rep;
        gcnt_n    = gcnt;
        emit      = 1'b0;
        emit_data = '0;
        emit_last = 1'b0;
        i.tready  = 1'b0;
        case (state)
            IDLE:
                if (i.tvalid) state_n = reps != 0 ? PREAMBLE : gap != 0 ? GAP : PAYLOAD;
            PREAMBLE:
                if (load) begin
                    emit      = 1'b1;
                    emit_data = rd;
                    // per_s of 0 gives an all-ones limit, i.e. a 2**AW period
                    if (idx == per_s - 1'b1) begin
                        idx_n = '0;
                        rep_n = rep + 8'd1;
                        if (rep == reps_s - 8'd1) begin
                            rep_n   = '0;
                            state_n = gap_s != 0 ? GAP : PAYLOAD;
                        end
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            GAP:
                if (load) begin
                    emit   = 1'b1;
                    gcnt_n = gcnt + 16'd1;
                    if (gcnt == gap_s - 16'd1) begin
                        gcnt_n  = '0;
                        state_n = PAYLOAD;
                    end
                end
            PAYLOAD: begin
                i.tready = load & ~clear;
                if (load && i.tvalid) begin
                    emit      = 1'b1;
                    emit_data = i.tdata;
                    emit_last = i.tlast;
                    if (i.tlast) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (clear || !resetn) begin
            state_n = IDLE;
            idx_n   = '0;
            rep_n   = '0;
            gcnt_n  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            o.tvalid <= 1'b0;
            o.tdata  <= '0;
            o.tlast  <= 1'b0;
            idx      <= '0;
            rep      <= '0;
            gcnt     <= '0;
            per      <= AW'(16);
            reps     <= 8'd10;
            gap      <= '0;
            per_s    <= AW'(16);
            reps_s   <= 8'd10;
            gap_s    <= '0;
            wptr     <= '0;
        end else begin
            idx  <= idx_n;
            rep  <= rep_n;
            gcnt <= gcnt_n;
            if (clear) begin
                o.tvalid <= 1'b0;
            end else if (load) begin
                o.tvalid <= emit;
                if (emit) begin
                    o.tdata <= emit_data;
                    o.tlast <= emit_last;
                end
            end
            if (state == IDLE && state_n != IDLE) begin
                per_s  <= per;
                reps_s <= reps;
                gap_s  <= gap;
            end
            if (set_stb) begin
                if (set_addr == A_P) per <= set_data[AW-1:0];
                if (set_addr == A_R) reps <= set_data[7:0];
                if (set_addr == A_G) gap <= set_data[15:0];
                if (set_addr == A_T) wptr <= wptr + 1'b1;
                if (set_addr == A_W) wptr <= '0;
            end
        end
    end

    // rd always holds table[idx]; idx_n only moves when the output loads,
    // so backpressure neither skips nor repeats entries
    always_ff @(posedge clk) begin
        if (set_stb && set_addr == A_T) mem[wptr] <= set_data;
        rd <= mem[idx_n];
    end
endmodule

// File: doc/sc_preamble_inserter.md
SC_PREAMBLE_INSERTER -- requirements
Module: sc_preamble_inserter

Interface
REQ-001 Parameter BASE, default 0: settings-bus base address.
REQ-002 Parameter MAX_LEN_LOG2, default 8: log2 of preamble table depth (256 entries).
REQ-003 Port clk, input, 1: sole clock; all logic rising-edge.
REQ-004 Port resetn, input, 1: synchronous, active-low reset.
REQ-005 Port clear, input, 1: synchronous active-high frame abort; settings and table retained.
REQ-006 Port set_stb, input, 1: settings write strobe.
REQ-007 Port set_addr, input, 8: settings address.
REQ-008 Port set_data, input, 32: settings data.
REQ-009 Port i_tdata, input, 32: payload sample, I in [31:16], Q in [15:0].
REQ-010 Port i_tlast, input, 1: last payload sample of frame.
REQ-011 Port i_tvalid, input, 1: payload valid.
REQ-012 Port i_tready, output, 1: payload accepted.
REQ-013 Port o_tdata, output, 32: preamble, gap or payload sample, same I/Q packing.
REQ-014 Port o_tlast, output, 1: asserted only on the final payload sample.
REQ-015 Port o_tvalid, output, 1: output valid.
REQ-016 Port o_tready, input, 1: downstream ready.
REQ-017 Port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-018 Settings: BASE+0 [7:0] period P (0 means 256), default 16; BASE+1 [7:0] repetitions R, default 10; BASE+2 [15:0] gap length G, default 0; BASE+3 writes set_data to table[wptr], then wptr increments mod 256; BASE+4 (any data) sets wptr=0.
REQ-019 P, R and G are shadowed on the IDLE->PREAMBLE/GAP/PAYLOAD transition; writes during a frame take effect on the next frame; table writes during a frame are permitted, and a read of the same entry in that frame returns old or new data without corrupting other entries.
REQ-020 FSM states: IDLE, PREAMBLE, GAP, PAYLOAD.
REQ-021 IDLE: i_tready=0; on i_tvalid=1, go to PREAMBLE if R>0, else GAP if G>0, else PAYLOAD; the first payload sample is not consumed in IDLE.
REQ-022 PREAMBLE: emit table[0..P-1] in order, R times (P*R samples total, I/Q unchanged); after the last, go to GAP if G>0, else PAYLOAD.
REQ-023 GAP: emit exactly G samples of 32'h0, then PAYLOAD.
REQ-024 PAYLOAD: pass i_tdata/i_tlast through unmodified; i_tready=1 only when the output register can load (o_tready | ~o_tvalid); after accepting a beat with i_tlast=1, go to IDLE.
REQ-025 Output is a single registered stage: a beat transfers when o_tvalid & o_tready; o_tdata/o_tlast are stable while o_tvalid=1 and o_tready=0.
REQ-026 Throughput: one sample per clock with o_tready held high, including across state boundaries; no bubble between preamble, gap and payload when input is valid.
REQ-027 Latency: first preamble sample at o_tvalid no later than 3 cycles after i_tvalid rises in IDLE; payload latency is 1 cycle (input beat to o_tvalid).
REQ-028 Table read is a synchronous RAM read; the read address is advanced only when the output register loads, so backpressure never skips or repeats table entries.
REQ-029 Counters: sample index within a period (8 bits, wraps at P), repetition counter (8 bits), gap counter (16 bits); a period of P=256 wraps index 255 to 0.
REQ-030 o_tlast is 0 for every preamble and gap sample.
REQ-031 clear=1: FSM to IDLE, o_tvalid=0 next cycle, counters zeroed, and any in-flight output beat dropped; clear takes priority over a simultaneous handshake.

Reset
REQ-032 On resetn=0: FSM=IDLE, o_tvalid=0, o_tdata=0, o_tlast=0, i_tready=0, busy=0, P=16, R=10, G=0, wptr=0; table contents are not reset.
REQ-033 Reset mid-frame aborts the frame with the same result as REQ-032; the residual input beats are treated as a new frame after reset.

Verification
REQ-034 Table loaded 0..15, P=16, R=2, G=0; 4-sample frame 0xA..0xD with o_tready=1 -> output 0..15, 0..15, A..D, o_tlast only on D, 36 contiguous beats.
REQ-035 P=4, R=1, G=3, frame of 2 samples -> table[0..3], 0, 0, 0, payload, 9 beats, busy falls after the tlast beat.
REQ-036 R=0, G=0 -> output equals input beat-for-beat with 1-cycle latency.
REQ-037 o_tready random 50% during P=16, R=10 -> exactly 160 preamble beats in correct order, none duplicated.
REQ-038 clear asserted at preamble beat 7 -> o_tvalid=0 next cycle; the next frame restarts at table[0].
REQ-039 Writing P=8 mid-frame -> the current frame uses 16-sample periods and the next frame uses 8.
